// File: rtl/seq_scan_ctrl_if.sv
// Word/pattern handshake bundle between a word source (master) and seq_scan_ctrl (slave).
interface seq_scan_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic [PAT_W-1:0]  pat_in;
    logic              pat_load;

    modport master (output word_in, word_valid, pat_in, pat_load, input word_ready);
    modport slave  (input word_in, word_valid, pat_in, pat_load, output word_ready);
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serialises an accepted word MSB-first and counts matches against a programmable pattern.
// Define SEQ_OVERLAP_EN for overlapping detection; default is non-overlapping.
module seq_scan_ctrl #(
    parameter int               WORD_W  = 16,
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 5,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b0101)
) (
    input  logic             clk,
    input  logic             rst,
    seq_scan_ctrl_if.slave   bus,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             busy
);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FW = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nx;
    logic [WORD_W-1:0] shreg;
    logic [PAT_W-1:0]  pattern, hist, hist_n;
    logic [FW-1:0]     fill;
    logic [BW-1:0]     bit_cnt;
    logic              accept, hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: if (bus.word_valid) begin
                accept   = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: if (bit_cnt == BW'(WORD_W - 1)) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.word_ready = (state == IDLE);
    assign bit_valid      = (state == SHIFT);
    assign bit_out        = bit_valid & shreg[WORD_W-1];
    assign done           = (state == DONE);
    assign busy           = (state != IDLE);

    // fill counts bits already in history; a match needs PAT_W-1 of them plus the current bit
    assign hist_n = {hist[PAT_W-2:0], shreg[WORD_W-1]};
    assign hit    = (fill >= FW'(PAT_W - 1)) && (hist_n == pattern);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern     <= PAT_RST;
            shreg       <= '0;
            hist        <= '0;
            fill        <= '0;
            bit_cnt     <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.pat_load) pattern <= bus.pat_in;
                    if (accept) begin
                        shreg       <= bus.word_in;
                        bit_cnt     <= '0;
                        hist        <= '0;
                        fill        <= '0;
                        match_count <= '0;
                    end
                end
                SHIFT: begin
                    hist    <= hist_n;
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (hit) begin
                        match <= 1'b1;
                        if (match_count != '1) match_count <= match_count + 1'b1;
                    end
`ifdef SEQ_OVERLAP_EN
                    if (fill != FW'(PAT_W)) fill <= fill + 1'b1;
`else
                    if (hit)                     fill <= '0;
                    else if (fill != FW'(PAT_W)) fill <= fill + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: vector table plus reset-abort and held-input sequences.
module tb_seq_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    seq_scan_ctrl_if #(.WORD_W(16), .PAT_W(4)) wif ();
    seq_scan_ctrl_if #(.WORD_W(16), .PAT_W(4)) wif2 ();
    assign wif2.word_in    = wif.word_in;
    assign wif2.word_valid = wif.word_valid;
    assign wif2.pat_in     = wif.pat_in;
    assign wif2.pat_load   = wif.pat_load;

    logic       bit_out, bit_valid, match, done, busy;
    logic [4:0] match_count;
    logic       bit_out2, bit_valid2, match2, done2, busy2;
    logic [1:0] match_count2;

    seq_scan_ctrl #(.WORD_W(16), .PAT_W(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .bus(wif.slave),
        .bit_out(bit_out), .bit_valid(bit_valid), .match(match),
        .match_count(match_count), .done(done), .busy(busy));

    // narrow counter copy, driven identically, to exercise saturation
    seq_scan_ctrl #(.WORD_W(16), .PAT_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(wif2.slave),
        .bit_out(bit_out2), .bit_valid(bit_valid2), .match(match2),
        .match_count(match_count2), .done(done2), .busy(busy2));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        pl;
        logic [3:0]  pi;
        logic [15:0] w;
        int          cnt;
        logic [15:0] mask;
    } vec_t;

    // Called at a negedge in IDLE; the word is accepted at the next posedge (edge 0).
    task automatic scan(input logic pl, input logic [3:0] pi, input logic [15:0] w,
                        input bit hold, input int exp_cnt, input logic [15:0] exp_mask,
                        input string tag);
        logic [15:0] bits, m1, m2;
        int          done_cyc;
        bit          flow_ok;
        bits = '0; m1 = '0; m2 = '0; done_cyc = -1; flow_ok = 1'b1;
        check($sformatf("%s ready_before", tag), wif.word_ready, 1);
        wif.word_in = w; wif.word_valid = 1'b1; wif.pat_load = pl; wif.pat_in = pi;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    wif.word_in = 16'hFFFF; wif.pat_in = 4'hF;
                    wif.pat_load = 1'b1; wif.word_valid = 1'b1;
                end else begin
                    wif.pat_load = 1'b0; wif.word_valid = 1'b0;
                end
            end
            if (k <= 16) begin
                bits[16-k] = bit_out;
                if (!bit_valid || wif.word_ready || !busy || !bit_valid2) flow_ok = 1'b0;
            end
            if (k >= 2 && k <= 17) begin
                if (match)  m1[k-2] = 1'b1;
                if (match2) m2[k-2] = 1'b1;
            end
            if (done !== done2) flow_ok = 1'b0;
            if (done) done_cyc = (done_cyc < 0) ? k : 99;
            if (k == 17) begin
                if (!busy || wif.word_ready) flow_ok = 1'b0;
                check($sformatf("%s count", tag), 32'(match_count), exp_cnt);
                check($sformatf("%s count_sat", tag), 32'(match_count2), (exp_cnt > 3) ? 3 : exp_cnt);
            end
            if (k == 18 && (!wif.word_ready || busy || bit_valid || match)) flow_ok = 1'b0;
        end
        check($sformatf("%s bitstream", tag), bits, w);
        check($sformatf("%s match_mask", tag), m1, exp_mask);
        check($sformatf("%s match_mask_sat", tag), m2, exp_mask);
        check($sformatf("%s done_cycle", tag), done_cyc, 17);
        check($sformatf("%s flow", tag), flow_ok, 1);
    endtask

    vec_t vecs[6];

    initial begin
        bit stay_idle;
        vecs[0] = '{1'b0, 4'h0, 16'h5555, OV ? 7 : 4,  OV ? 16'hAAA8 : 16'h8888};
        vecs[1] = '{1'b0, 4'h0, 16'h0000, 0,           16'h0000};
        vecs[2] = '{1'b1, 4'hF, 16'hFFFF, OV ? 13 : 4, OV ? 16'hFFF8 : 16'h8888};
        vecs[3] = '{1'b1, 4'h9, 16'h9249, OV ? 5 : 3,  OV ? 16'h9248 : 16'h8208};
        vecs[4] = '{1'b1, 4'h6, 16'h6666, 4,           16'h8888};
        vecs[5] = '{1'b1, 4'h5, 16'hA5A5, 2,           16'h8080};

        wif.word_in = '0; wif.word_valid = 1'b0; wif.pat_in = '0; wif.pat_load = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset outputs", {bit_out, bit_valid, match, done, busy, match_count}, 0);
        check("reset ready", wif.word_ready, 1);
        rst = 1'b1;

        for (int i = 0; i < 6; i++)
            scan(vecs[i].pl, vecs[i].pi, vecs[i].w, 1'b0, vecs[i].cnt, vecs[i].mask,
                 $sformatf("vec%0d", i));

        // abort mid-scan with a non-default pattern loaded
        wif.word_in = 16'hFFFF; wif.word_valid = 1'b1; wif.pat_load = 1'b1; wif.pat_in = 4'hF;
        @(negedge clk);
        wif.word_valid = 1'b0; wif.pat_load = 1'b0;
        repeat (9) @(negedge clk);
        check("abort count_before", 32'(match_count), OV ? 6 : 2);
        rst = 1'b0;
        #1;
        check("abort outputs", {bit_out, bit_valid, match, done, busy, match_count}, 0);
        check("abort ready", wif.word_ready, 1);
        stay_idle = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy || !wif.word_ready) stay_idle = 1'b0;
        end
        check("abort no_done", stay_idle, 1);
        rst = 1'b1;
        scan(1'b0, 4'h0, 16'h5555, 1'b0, OV ? 7 : 4, OV ? 16'hAAA8 : 16'h8888, "post_reset_pat");

        // inputs held high through the scan: pattern unchanged, second word taken in cycle 18
        scan(1'b0, 4'h0, 16'h5555, 1'b1, OV ? 7 : 4, OV ? 16'hAAA8 : 16'h8888, "held_first");
        scan(1'b1, 4'hF, 16'hFFFF, 1'b0, OV ? 13 : 4, OV ? 16'hFFF8 : 16'h8888, "held_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
